// File: rtl/bounding_box.sv
// Raster-scans a WIDTH x HEIGHT image from a synchronous-read RAM and reports the
// bounding box of foreground pixels. Define BOUNDINGBOX_THRESHOLD_EN for a threshold test.
module bounding_box #(
  parameter int          WIDTH     = 160,
  parameter int          HEIGHT    = 120,
  parameter logic [23:0] BASE_ADDR = 24'h0,
  parameter logic [15:0] THRESH    = 16'h0001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        done,
  input  logic [15:0] rddata,
  output logic [23:0] addr,
  output logic [10:0] xMin,
  output logic [10:0] xMax,
  output logic [10:0] yMin,
  output logic [10:0] yMax
);

  localparam logic [10:0] LAST_X  = 11'(WIDTH - 1);
  localparam logic [10:0] LAST_Y  = 11'(HEIGHT - 1);
  localparam logic [23:0] WIDTH24 = 24'(WIDTH);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t      state_reg;
  logic [10:0] x_reg, y_reg;
  logic [10:0] px_reg, py_reg;
  logic        pvalid_reg;
  logic [10:0] run_x_min_reg, run_x_max_reg, run_y_min_reg, run_y_max_reg;

  logic        is_fg;
  logic        hit;
  logic        last;
  logic [10:0] x_next, y_next;
  logic [23:0] addr_next;
  logic [10:0] x_min_upd, x_max_upd, y_min_upd, y_max_upd;

`ifdef BOUNDINGBOX_THRESHOLD_EN
  assign is_fg = (rddata >= THRESH);
`else
  assign is_fg = |rddata;
`endif

  // rddata belongs to the pixel whose coordinates were latched into px/py one edge ago
  assign hit  = pvalid_reg & is_fg;
  assign last = (x_reg == LAST_X) && (y_reg == LAST_Y);

  always_comb begin
    x_next = x_reg + 11'd1;
    y_next = y_reg;
    if (x_reg == LAST_X) begin
      x_next = 11'd0;
      y_next = y_reg + 11'd1;
    end
    addr_next = BASE_ADDR + ({13'd0, y_next} * WIDTH24) + {13'd0, x_next};
  end

  always_comb begin
    x_min_upd = run_x_min_reg;
    x_max_upd = run_x_max_reg;
    y_min_upd = run_y_min_reg;
    y_max_upd = run_y_max_reg;
    if (hit) begin
      if (px_reg < run_x_min_reg) x_min_upd = px_reg;
      if (px_reg > run_x_max_reg) x_max_upd = px_reg;
      if (py_reg < run_y_min_reg) y_min_upd = py_reg;
      if (py_reg > run_y_max_reg) y_max_upd = py_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      done          <= 1'b0;
      addr          <= BASE_ADDR;
      x_reg         <= 11'd0;
      y_reg         <= 11'd0;
      px_reg        <= 11'd0;
      py_reg        <= 11'd0;
      pvalid_reg    <= 1'b0;
      run_x_min_reg <= 11'h7FF;
      run_x_max_reg <= 11'd0;
      run_y_min_reg <= 11'h7FF;
      run_y_max_reg <= 11'd0;
      xMin          <= 11'h7FF;
      xMax          <= 11'd0;
      yMin          <= 11'h7FF;
      yMax          <= 11'd0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            state_reg     <= SCAN;
            done          <= 1'b0;
            addr          <= BASE_ADDR;
            x_reg         <= 11'd0;
            y_reg         <= 11'd0;
            pvalid_reg    <= 1'b0;
            run_x_min_reg <= 11'h7FF;
            run_x_max_reg <= 11'd0;
            run_y_min_reg <= 11'h7FF;
            run_y_max_reg <= 11'd0;
          end
        end
        SCAN: begin
          run_x_min_reg <= x_min_upd;
          run_x_max_reg <= x_max_upd;
          run_y_min_reg <= y_min_upd;
          run_y_max_reg <= y_max_upd;
          px_reg        <= x_reg;
          py_reg        <= y_reg;
          pvalid_reg    <= 1'b1;
          if (last) begin
            state_reg <= DRAIN;
          end else begin
            x_reg <= x_next;
            y_reg <= y_next;
            addr  <= addr_next;
          end
        end
        DRAIN: begin
          // Outputs take the last pixel's contribution directly from the update logic
          run_x_min_reg <= x_min_upd;
          run_x_max_reg <= x_max_upd;
          run_y_min_reg <= y_min_upd;
          run_y_max_reg <= y_max_upd;
          xMin          <= x_min_upd;
          xMax          <= x_max_upd;
          yMin          <= y_min_upd;
          yMax          <= y_max_upd;
          pvalid_reg    <= 1'b0;
          done          <= 1'b1;
          state_reg     <= DONE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bounding_box.sv
// Bench for bounding_box on an 8x4 image in a 32-word synchronous RAM; results are
// compared with a bounding box computed directly from the RAM contents.
module tb_bounding_box;

  localparam int W = 8;
  localparam int H = 4;
  localparam int N = W * H;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        done;
  logic [15:0] rddata = 16'h0;
  logic [23:0] addr;
  logic [10:0] xMin, xMax, yMin, yMax;

  logic [15:0] mem [0:N-1];
  int tests = 0;
  int fails = 0;

  bounding_box #(
    .WIDTH(W), .HEIGHT(H), .BASE_ADDR(24'h0), .THRESH(16'h0080)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .done(done), .rddata(rddata),
    .addr(addr), .xMin(xMin), .xMax(xMax), .yMin(yMin), .yMax(yMax)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rddata <= mem[addr[4:0]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit ref_fg(input logic [15:0] v);
`ifdef BOUNDINGBOX_THRESHOLD_EN
    return v >= 16'h0080;
`else
    return v != 16'h0;
`endif
  endfunction

  task automatic check_model(input string tag);
    int xmn = 2047, xmx = 0, ymn = 2047, ymx = 0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        if (ref_fg(mem[y*W + x])) begin
          if (x < xmn) xmn = x;
          if (x > xmx) xmx = x;
          if (y < ymn) ymn = y;
          if (y > ymx) ymx = y;
        end
    check({tag, ".done"}, 32'(done), 32'd1);
    check({tag, ".xMin"}, 32'(xMin), 32'(xmn));
    check({tag, ".xMax"}, 32'(xMax), 32'(xmx));
    check({tag, ".yMin"}, 32'(yMin), 32'(ymn));
    check({tag, ".yMax"}, 32'(yMax), 32'(ymx));
    $display("[TB] %s: box %0d/%0d/%0d/%0d model %0d/%0d/%0d/%0d", tag,
             xMin, xMax, yMin, yMax, xmn, xmx, ymn, ymx);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < N; i++) mem[i] = 16'h0;
  endtask

  // Pulse (or hold) start, follow the address sequence and measure done latency
  task automatic run_scan(input string tag, input bit hold);
    int lat = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    check({tag, ".done_low_after_start"}, 32'(done), 32'd0);
    check({tag, ".addr0"}, 32'(addr), 32'd0);
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (k < N && addr !== 24'(k)) check({tag, ".addr_seq"}, 32'(addr), 32'(k));
      if (done) begin
        lat = k;
        break;
      end
    end
    start = 1'b0;
    check({tag, ".latency"}, 32'(lat), 32'(N + 1));
  endtask

  task automatic check_const(input string tag, input int a, input int b, input int c, input int d);
    check({tag, ".c_xMin"}, 32'(xMin), 32'(a));
    check({tag, ".c_xMax"}, 32'(xMax), 32'(b));
    check({tag, ".c_yMin"}, 32'(yMin), 32'(c));
    check({tag, ".c_yMax"}, 32'(yMax), 32'(d));
  endtask

  initial begin
    clear_mem();
    repeat (2) @(posedge clk);
    #1;
    check("reset.done", 32'(done), 32'd0);
    check("reset.addr", 32'(addr), 32'd0);
    check_const("reset", 2047, 0, 2047, 0);
    @(negedge clk);
    rst_n = 1'b1;

    mem[19] = 16'h00FF;
    run_scan("single", 1'b0);
    check_model("single");
    check_const("single", 3, 3, 2, 2);

    clear_mem();
    run_scan("empty", 1'b0);
    check_model("empty");
    check_const("empty", 2047, 0, 2047, 0);

    clear_mem();
    mem[0]  = 16'h8001;
    mem[31] = 16'hFFFF;
    run_scan("corners", 1'b0);
    check_model("corners");
    check_const("corners", 0, 7, 0, 3);

    clear_mem();
    mem[13] = 16'h0100;
    check("restart.done_before", 32'(done), 32'd1);
    run_scan("restart", 1'b0);
    check_model("restart");
    check_const("restart", 5, 5, 1, 1);

    // Reset ten cycles into a scan
    mem[2] = 16'h00F0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst.done", 32'(done), 32'd0);
    check("midrst.addr", 32'(addr), 32'd0);
    check_const("midrst", 2047, 0, 2047, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("midrst.idle_done", 32'(done), 32'd0);
    check("midrst.idle_addr", 32'(addr), 32'd0);
    run_scan("after_rst", 1'b0);
    check_model("after_rst");

    mem[31] = 16'h0040;
    run_scan("hold_start", 1'b1);
    check_model("hold_start");

    clear_mem();
    mem[9]  = 16'h007F;
    mem[22] = 16'h0080;
    run_scan("thresh", 1'b0);
    check_model("thresh");
`ifdef BOUNDINGBOX_THRESHOLD_EN
    check_const("thresh", 6, 6, 2, 2);
`else
    check_const("thresh", 1, 6, 1, 2);
`endif

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N; i++)
        mem[i] = ($urandom_range(0, 5) == 0) ? 16'($urandom_range(1, 16'hFFFF) >> $urandom_range(0, 15)) : 16'h0;
      run_scan($sformatf("rand%0d", r), 1'b0);
      check_model($sformatf("rand%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
